fp_seq_multiplier: RTL

- Multi-cycle IEEE-754 single-precision multiplier: the inverse operation of the ALU's combinational divider.
- Trades the single-cycle 24x24 array for a shift-and-add datapath over 24/BITS_PER_CYCLE cycles.
- Sits beside the Newton-Raphson divider in the float ALU of the odometry datapath.
- Used where area matters more than latency, e.g. wheel-tick to distance scaling.

---
 rtl/fp_alu_pkg.sv | 22 ++
 rtl/fp_mul_normalize.sv | 67 ++++++
 rtl/fp_seq_multiplier.sv | 103 ++++++++++
 3 files changed

// File: rtl/fp_alu_pkg.sv
// Shared float ALU types and constants.
// Used by the sequential multiplier and its normaliser.
package fp_alu_pkg;

    localparam int FP_BIAS = 127;
    localparam logic [7:0] FP_EXP_MAX = 8'hFF;
    localparam int FP_MANT_W = 23;

    typedef struct packed {
        logic                 sign;
        logic [7:0]           exp;
        logic [FP_MANT_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } mul_state_e;

endpackage

// File: rtl/fp_mul_normalize.sv
// Combinational NORM stage: exponent, special cases, rounding.
// ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp_mul_normalize
    import fp_alu_pkg::*;
(
    input  logic        sign,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [47:0] prod,
    output fp32_t       result,
    output logic        exception
);

    logic                 norm;
    logic [22:0]          mant;
    logic [9:0]           exp_raw;
    logic signed [9:0]    exp_sum;
    logic signed [9:0]    exp_fin;
    logic [22:0]          mant_fin;

`ifdef ROUND_NEAREST_EN
    logic        guard;
    logic        sticky;
    logic        rnd_up;
    logic [23:0] mant_rnd;
`else
    logic unused_low;
    assign unused_low = ^prod[21:0];
`endif

    always_comb begin
        norm    = prod[47];
        mant    = norm ? prod[46:24] : prod[45:23];
        exp_raw = {2'b00, exp_a} + {2'b00, exp_b}
                + {9'd0, norm} - 10'(FP_BIAS);
        exp_sum = $signed(exp_raw);
`ifdef ROUND_NEAREST_EN
        guard    = norm ? prod[23] : prod[22];
        sticky   = norm ? |prod[22:0] : |prod[21:0];
        rnd_up   = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, rnd_up};
        // carry-out means significand hit 2.0: frac wraps to 0
        mant_fin = mant_rnd[22:0];
        exp_fin  = exp_sum + $signed({9'd0, mant_rnd[23]});
`else
        mant_fin = mant;
        exp_fin  = exp_sum;
`endif
        exception = 1'b0;
        result    = '{sign: sign, exp: 8'h00, frac: '0};
        if (exp_a == FP_EXP_MAX || exp_b == FP_EXP_MAX) begin
            exception  = 1'b1;
            result.exp = FP_EXP_MAX;
        end else if (exp_a == 8'h00 || exp_b == 8'h00) begin
            exception = 1'b0;
        end else if (exp_fin >= 10'sd255) begin
            exception  = 1'b1;
            result.exp = FP_EXP_MAX;
        end else if (exp_fin <= 10'sd0) begin
            exception = 1'b0;
        end else begin
            result.exp  = exp_fin[7:0];
            result.frac = mant_fin;
        end
    end

endmodule

// File: rtl/fp_seq_multiplier.sv
// Shift-and-add IEEE-754 single multiplier, BITS_PER_CYCLE bits/cycle.
// Optional ROUND_NEAREST_EN enables RNE rounding in fp_mul_normalize.
module fp_seq_multiplier
    import fp_alu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        busy,
    output logic        done,
    output logic        Exception,
    output logic [31:0] result
);

    localparam int STEPS = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST = 5'(STEPS - 1);

    mul_state_e  state;
    logic        sign_q;
    logic [7:0]  exp_a_q;
    logic [7:0]  exp_b_q;
    logic [47:0] mcand;
    logic [23:0] mplier;
    logic [47:0] acc;
    logic [4:0]  cnt;
    logic [47:0] pp_sum;
    fp32_t       norm_res;
    logic        norm_exc;

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) pp_sum = pp_sum + (mcand << i);
        end
    end

    fp_mul_normalize u_norm (
        .sign      (sign_q),
        .exp_a     (exp_a_q),
        .exp_b     (exp_b_q),
        .prod      (acc),
        .result    (norm_res),
        .exception (norm_exc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            Exception <= 1'b0;
            result    <= 32'h0;
            sign_q    <= 1'b0;
            exp_a_q   <= 8'h0;
            exp_b_q   <= 8'h0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_q  <= a_operand[31] ^ b_operand[31];
                        exp_a_q <= a_operand[30:23];
                        exp_b_q <= b_operand[30:23];
                        mcand   <= {24'd0, 1'b1, a_operand[22:0]};
                        mplier  <= {1'b1, b_operand[22:0]};
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    acc    <= acc + pp_sum;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 5'd1;
                    if (cnt == LAST) state <= NORM;
                end
                NORM: begin
                    result    <= norm_res;
                    Exception <= norm_exc;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
